// File: rtl/bcd_xs3_pkg.sv
// bcd_xs3_pkg: shared types and constants for the BCD/excess-3 converter
package bcd_xs3_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;
    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic       MODE_B2X   = 1'b0;
    localparam logic       MODE_X2B   = 1'b1;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;
endpackage

// File: rtl/xs3_digit.sv
// xs3_digit: combinational single-digit BCD<->XS3 converter with range flag
module xs3_digit
    import bcd_xs3_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       bad
);
    // modulo-16 offset add/subtract; range check against the captured mode
    always_comb begin
        q   = (mode == MODE_X2B) ? d - XS3_OFFSET : d + XS3_OFFSET;
        bad = (mode == MODE_X2B) ? (d < XS3_MIN || d > XS3_MAX) : (d > BCD_MAX);
    end
endmodule

// File: rtl/bcd_xs3_conv.sv
// bcd_xs3_conv: sequential multi-digit BCD/XS3 converter, one digit per clock, LSD first; BCD_XS3_ERR_CHECK_EN enables the sticky err flag
module bcd_xs3_conv
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] din,
    output logic [4*DIGITS-1:0] dout,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    conv_state_t         state, nxt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] work;
    logic                mode_r;
    logic [3:0]          cur, q;
    logic                bad, accept, last;

    assign accept = (state == IDLE) && start;
    assign last   = (idx == IW'(DIGITS - 1));
    assign cur    = work[{idx, 2'b00} +: 4];

    xs3_digit u_digit (
        .mode (mode_r),
        .d    (cur),
        .q    (q),
        .bad  (bad)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next state: DONE always lasts exactly one cycle
    always_comb begin
        nxt = (state == IDLE) ? (start ? CONV : IDLE) :
              (state == CONV) ? (last ? DONE : CONV) : IDLE;
    end

    // status outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // datapath: capture on accepted start, write one converted digit per CONV edge
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            work   <= '0;
            mode_r <= MODE_B2X;
            dout   <= '0;
        end else if (accept) begin
            idx    <= '0;
            work   <= din;
            mode_r <= mode;
            dout   <= '0;
        end else if (state == CONV) begin
            dout[{idx, 2'b00} +: 4] <= q;
            idx                     <= idx + IW'(1);
        end
    end

`ifdef BCD_XS3_ERR_CHECK_EN
    logic err_q;
    // sticky invalid-digit flag, cleared by each accepted start
    always_ff @(posedge clk) begin
        if (rst || accept)             err_q <= 1'b0;
        else if (state == CONV && bad) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    logic unused_bad;
    assign unused_bad = bad;
    assign err        = 1'b0;
`endif
endmodule
